// File: rtl/game_of_life_engine.sv
// Parametrised Conway Life (B3/S23) engine on a ROWS x COLS grid.
// Supports toroidal or dead-edge boundaries, row-serial LFSR seeding,
// a saturating generation counter with optional max-generation halt,
// and stable/extinct detection. Cell (r,c) lives at bit N-1-(r*COLS+c).
module game_of_life_engine #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int WRAP  = 0,
  parameter int GEN_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   lfsr_begin,
  input  logic                   load,
  input  logic [ROWS*COLS-1:0]   seed,
  input  logic [31:0]            lfsr_seed,
  input  logic [GEN_W-1:0]       max_gen,
  output logic [ROWS*COLS-1:0]   grid_evolve,
  output logic [1:0]             curr_state,
  output logic [GEN_W-1:0]       gen_count,
  output logic                   stable,
  output logic                   extinct,
  output logic                   done
);

  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    RUN  = 2'b10,
    HALT = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     grid_q, grid_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             stable_q, stable_d;
  logic             extinct_q, extinct_d;
  logic             done_q, done_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [RW-1:0]    row_q, row_d;

  logic [N-1:0]     next_grid;
  logic [31:0]      lfsr_nxt;
  logic [GEN_W-1:0] gen_inc;

  // Galois right-shift LFSR step used during row-serial fill
  assign lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
  assign gen_inc  = gen_q + 1'b1;

  // Per-cell neighbour count and B3/S23 rule; all indices are elaboration
  // constants, out-of-grid neighbours are forced dead unless WRAP is set.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      localparam int RU = (gr == 0)        ? ROWS - 1 : gr - 1;
      localparam int RD = (gr == ROWS - 1) ? 0        : gr + 1;
      localparam int CL = (gc == 0)        ? COLS - 1 : gc - 1;
      localparam int CR = (gc == COLS - 1) ? 0        : gc + 1;
      localparam bit VU = (WRAP != 0) || (gr > 0);
      localparam bit VD = (WRAP != 0) || (gr < ROWS - 1);
      localparam bit VL = (WRAP != 0) || (gc > 0);
      localparam bit VR = (WRAP != 0) || (gc < COLS - 1);
      localparam int ISELF = N - 1 - (gr * COLS + gc);

      logic [7:0] nb;
      logic [3:0] cnt;

      assign nb[0] = (VU && VL) ? grid_q[N-1-(RU*COLS+CL)] : 1'b0;
      assign nb[1] = VU         ? grid_q[N-1-(RU*COLS+gc)] : 1'b0;
      assign nb[2] = (VU && VR) ? grid_q[N-1-(RU*COLS+CR)] : 1'b0;
      assign nb[3] = VL         ? grid_q[N-1-(gr*COLS+CL)] : 1'b0;
      assign nb[4] = VR         ? grid_q[N-1-(gr*COLS+CR)] : 1'b0;
      assign nb[5] = (VD && VL) ? grid_q[N-1-(RD*COLS+CL)] : 1'b0;
      assign nb[6] = VD         ? grid_q[N-1-(RD*COLS+gc)] : 1'b0;
      assign nb[7] = (VD && VR) ? grid_q[N-1-(RD*COLS+CR)] : 1'b0;

      assign cnt = {3'b0, nb[0]} + {3'b0, nb[1]} + {3'b0, nb[2]} + {3'b0, nb[3]}
                 + {3'b0, nb[4]} + {3'b0, nb[5]} + {3'b0, nb[6]} + {3'b0, nb[7]};

      assign next_grid[ISELF] = (cnt == 4'd3) || (grid_q[ISELF] && (cnt == 4'd2));
    end
  end

  // Next-state logic: mode sequencing, seeding, generation step and flags
  always_comb begin
    state_d   = state_q;
    grid_d    = grid_q;
    gen_d     = gen_q;
    stable_d  = stable_q;
    extinct_d = extinct_q;
    lfsr_d    = lfsr_q;
    row_d     = row_q;
    unique case (state_q)
      IDLE: begin
        if (lfsr_begin) begin
          lfsr_d    = (lfsr_seed == 32'h0) ? 32'h1 : lfsr_seed;
          row_d     = '0;
          gen_d     = '0;
          stable_d  = 1'b0;
          extinct_d = 1'b0;
          state_d   = FILL;
        end else if (load) begin
          grid_d    = seed;
          gen_d     = '0;
          stable_d  = 1'b0;
          extinct_d = 1'b0;
        end else if (start) begin
          state_d = RUN;
        end
      end
      FILL: begin
        for (int k = 0; k < ROWS; k++) begin
          if (row_q == RW'(k)) grid_d[N-1-k*COLS -: COLS] = lfsr_q[COLS-1:0];
        end
        lfsr_d = lfsr_nxt;
        row_d  = row_q + 1'b1;
        if (row_q == RW'(ROWS - 1)) state_d = IDLE;
      end
      RUN: begin
        if (start) begin
          grid_d    = next_grid;
          gen_d     = (&gen_q) ? gen_q : gen_inc;
          stable_d  = (next_grid == grid_q);
          extinct_d = (next_grid == '0);
          if ((next_grid == grid_q) || (next_grid == '0) ||
              ((max_gen != '0) && (gen_inc == max_gen))) begin
            state_d = HALT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HALT: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == HALT);
  end

  // State and datapath registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grid_q    <= '0;
      gen_q     <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
      done_q    <= 1'b0;
      lfsr_q    <= 32'h1;
      row_q     <= '0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      gen_q     <= gen_d;
      stable_q  <= stable_d;
      extinct_q <= extinct_d;
      done_q    <= done_d;
      lfsr_q    <= lfsr_d;
      row_q     <= row_d;
    end
  end

  assign grid_evolve = grid_q;
  assign curr_state  = state_q;
  assign gen_count   = gen_q;
  assign stable      = stable_q;
  assign extinct     = extinct_q;
  assign done        = done_q;

endmodule

// File: tb/tb_game_of_life_engine.sv
// Directed bench for game_of_life_engine: two 8x8 instances (dead-edge and
// toroidal) share stimulus; expected grids are hand-computed constants.
module tb_game_of_life_engine;

  localparam logic [63:0] BLINK_H = 64'h0000_3800_0000_0000;
  localparam logic [63:0] BLINK_V = 64'h0010_1010_0000_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
  localparam logic [63:0] SINGLE  = 64'h0000_0010_0000_0000;
  localparam logic [63:0] GLIDER  = 64'h4020_E000_0000_0000;
  localparam logic [63:0] G4      = 64'h0020_1070_0000_0000;
  localparam logic [63:0] G16     = 64'h0000_0000_0402_0E00;
  localparam logic [63:0] G20     = 64'h0000_0000_0002_0107;
  localparam logic [63:0] G21_W   = 64'h0200_0000_0000_0503;
  localparam logic [63:0] G21_D   = 64'h0000_0000_0000_0503;
  localparam logic [63:0] LFSR_G  = 64'h0103_0201_0302_0103;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        lfsr_begin = 1'b0;
  logic        load = 1'b0;
  logic [63:0] seed = '0;
  logic [31:0] lfsr_seed = '0;
  logic [15:0] max_gen = '0;

  logic [63:0] grid0, grid1;
  logic [1:0]  state0, state1;
  logic [15:0] gen0, gen1;
  logic        stable0, stable1, extinct0, extinct1, done0, done1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  game_of_life_engine #(.ROWS(8), .COLS(8), .WRAP(0), .GEN_W(16)) dut_dead (
    .clk(clk), .reset(reset), .start(start), .lfsr_begin(lfsr_begin), .load(load),
    .seed(seed), .lfsr_seed(lfsr_seed), .max_gen(max_gen),
    .grid_evolve(grid0), .curr_state(state0), .gen_count(gen0),
    .stable(stable0), .extinct(extinct0), .done(done0)
  );

  game_of_life_engine #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_W(16)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .lfsr_begin(lfsr_begin), .load(load),
    .seed(seed), .lfsr_seed(lfsr_seed), .max_gen(max_gen),
    .grid_evolve(grid1), .curr_state(state1), .gen_count(gen1),
    .stable(stable1), .extinct(extinct1), .done(done1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [63:0] s);
    @(negedge clk);
    seed = s;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (grid0 !== 64'h0) begin failures++; $display("FAIL reset_grid got=%h exp=0", grid0); end
    checks++; if (state0 !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", state0); end
    checks++; if ({gen0, stable0, extinct0, done0} !== 19'h0) begin failures++; $display("FAIL reset_flags got=%h exp=0", {gen0, stable0, extinct0, done0}); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_blinker();
    do_load(BLINK_H);
    max_gen = 16'd0;
    @(negedge clk);
    start = 1'b1;
    step();
    checks++; if (state0 !== 2'b10 || grid0 !== BLINK_H || gen0 !== 16'd0) begin failures++; $display("FAIL blink_enter_run state=%b grid=%h gen=%0d exp 10/%h/0", state0, grid0, gen0, BLINK_H); end
    step();
    checks++; if (grid0 !== BLINK_V) begin failures++; $display("FAIL blink_gen1 got=%h exp=%h", grid0, BLINK_V); end
    checks++; if (gen0 !== 16'd1 || stable0 !== 1'b0 || state0 !== 2'b10) begin failures++; $display("FAIL blink_gen1_ctl gen=%0d stable=%b state=%b exp 1/0/10", gen0, stable0, state0); end
    step();
    checks++; if (grid0 !== BLINK_H) begin failures++; $display("FAIL blink_gen2 got=%h exp=%h", grid0, BLINK_H); end
    checks++; if (gen0 !== 16'd2 || state0 !== 2'b10 || done0 !== 1'b0) begin failures++; $display("FAIL blink_gen2_ctl gen=%0d state=%b done=%b exp 2/10/0", gen0, state0, done0); end
    @(negedge clk);
    start = 1'b0;
    step();
    checks++; if (state0 !== 2'b00 || gen0 !== 16'd2 || grid0 !== BLINK_H) begin failures++; $display("FAIL blink_pause state=%b gen=%0d grid=%h exp 00/2/%h", state0, gen0, grid0, BLINK_H); end
  endtask

  task automatic test_max_gen();
    do_load(BLINK_H);
    max_gen = 16'd3;
    @(negedge clk);
    start = 1'b1;
    step();
    step();
    step();
    checks++; if (state0 !== 2'b10 || gen0 !== 16'd2) begin failures++; $display("FAIL maxgen_pre state=%b gen=%0d exp 10/2", state0, gen0); end
    step();
    checks++; if (state0 !== 2'b11 || gen0 !== 16'd3 || done0 !== 1'b1 || grid0 !== BLINK_V) begin failures++; $display("FAIL maxgen_halt state=%b gen=%0d done=%b grid=%h exp 11/3/1/%h", state0, gen0, done0, grid0, BLINK_V); end
    @(negedge clk);
    start = 1'b0;
    max_gen = 16'd0;
    step();
  endtask

  task automatic test_block();
    do_load(BLOCK);
    @(negedge clk);
    start = 1'b1;
    step();
    step();
    checks++; if (stable0 !== 1'b1 || state0 !== 2'b11 || done0 !== 1'b1) begin failures++; $display("FAIL block_halt stable=%b state=%b done=%b exp 1/11/1", stable0, state0, done0); end
    checks++; if (gen0 !== 16'd1 || grid0 !== BLOCK || extinct0 !== 1'b0) begin failures++; $display("FAIL block_grid gen=%0d grid=%h ext=%b exp 1/%h/0", gen0, grid0, extinct0, BLOCK); end
    @(negedge clk);
    start = 1'b0;
    step();
    checks++; if (state0 !== 2'b00 || stable0 !== 1'b1 || done0 !== 1'b0) begin failures++; $display("FAIL block_idle state=%b stable=%b done=%b exp 00/1/0", state0, stable0, done0); end
    @(negedge clk);
    start = 1'b1;
    step();
    checks++; if (state0 !== 2'b10) begin failures++; $display("FAIL block_rerun state=%b exp 10", state0); end
    step();
    checks++; if (state0 !== 2'b11 || gen0 !== 16'd2 || stable0 !== 1'b1) begin failures++; $display("FAIL block_rehalt state=%b gen=%0d stable=%b exp 11/2/1", state0, gen0, stable0); end
    @(negedge clk);
    start = 1'b0;
    step();
  endtask

  task automatic test_single();
    do_load(SINGLE);
    checks++; if (gen0 !== 16'd0 || stable0 !== 1'b0) begin failures++; $display("FAIL load_clears gen=%0d stable=%b exp 0/0", gen0, stable0); end
    @(negedge clk);
    start = 1'b1;
    step();
    step();
    checks++; if (extinct0 !== 1'b1 || grid0 !== 64'h0 || stable0 !== 1'b0) begin failures++; $display("FAIL single_extinct ext=%b grid=%h stable=%b exp 1/0/0", extinct0, grid0, stable0); end
    checks++; if (state0 !== 2'b11 || gen0 !== 16'd1) begin failures++; $display("FAIL single_halt state=%b gen=%0d exp 11/1", state0, gen0); end
    @(negedge clk);
    start = 1'b0;
    step();
  endtask

  task automatic test_empty();
    do_load(64'h0);
    @(negedge clk);
    start = 1'b1;
    step();
    step();
    checks++; if (stable0 !== 1'b1 || extinct0 !== 1'b1) begin failures++; $display("FAIL empty_flags stable=%b ext=%b exp 1/1", stable0, extinct0); end
    checks++; if (state0 !== 2'b11 || gen0 !== 16'd1) begin failures++; $display("FAIL empty_halt state=%b gen=%0d exp 11/1", state0, gen0); end
    @(negedge clk);
    start = 1'b0;
    step();
  endtask

  task automatic test_glider();
    do_load(GLIDER);
    max_gen = 16'd32;
    @(negedge clk);
    start = 1'b1;
    step();
    for (int g = 1; g <= 40; g++) begin
      step();
      if (g == 4) begin
        checks++; if (grid0 !== G4 || grid1 !== G4) begin failures++; $display("FAIL glider_g4 dead=%h wrap=%h exp=%h", grid0, grid1, G4); end
      end
      if (g == 16) begin
        checks++; if (grid0 !== G16 || grid1 !== G16) begin failures++; $display("FAIL glider_g16 dead=%h wrap=%h exp=%h", grid0, grid1, G16); end
      end
      if (g == 20) begin
        checks++; if (grid0 !== G20 || grid1 !== G20) begin failures++; $display("FAIL glider_g20 dead=%h wrap=%h exp=%h", grid0, grid1, G20); end
      end
      if (g == 21) begin
        checks++; if (grid1 !== G21_W) begin failures++; $display("FAIL glider_g21_wrap got=%h exp=%h", grid1, G21_W); end
        checks++; if (grid0 !== G21_D) begin failures++; $display("FAIL glider_g21_dead got=%h exp=%h", grid0, G21_D); end
      end
      if (done1 === 1'b1) break;
    end
    checks++; if (done1 !== 1'b1 || state1 !== 2'b11) begin failures++; $display("FAIL glider_halt done=%b state=%b exp 1/11", done1, state1); end
    checks++; if (gen1 !== 16'd32 || grid1 !== GLIDER) begin failures++; $display("FAIL glider_return gen=%0d grid=%h exp 32/%h", gen1, grid1, GLIDER); end
    @(negedge clk);
    start = 1'b0;
    max_gen = 16'd0;
    step();
  endtask

  task automatic test_lfsr();
    int fill_cycles;
    // plain fill from seed 1
    @(negedge clk);
    lfsr_seed = 32'h0000_0001;
    lfsr_begin = 1'b1;
    step();
    @(negedge clk);
    lfsr_begin = 1'b0;
    fill_cycles = (state0 == 2'b01) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      if (state0 != 2'b01) break;
      step();
      if (state0 == 2'b01) fill_cycles++;
    end
    checks++; if (fill_cycles !== 8 || state0 !== 2'b00) begin failures++; $display("FAIL lfsr_fill_len cycles=%0d state=%b exp 8/00", fill_cycles, state0); end
    checks++; if (grid0 !== LFSR_G) begin failures++; $display("FAIL lfsr_grid got=%h exp=%h", grid0, LFSR_G); end
    checks++; if (gen0 !== 16'd0 || stable0 !== 1'b0 || extinct0 !== 1'b0) begin failures++; $display("FAIL lfsr_clear gen=%0d stable=%b ext=%b exp 0/0/0", gen0, stable0, extinct0); end
    // zero seed with all three requests asserted together
    do_load(64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    lfsr_seed = 32'h0;
    lfsr_begin = 1'b1;
    load = 1'b1;
    start = 1'b1;
    step();
    checks++; if (state0 !== 2'b01) begin failures++; $display("FAIL priority_fill state=%b exp 01", state0); end
    @(negedge clk);
    lfsr_begin = 1'b0;
    fill_cycles = (state0 == 2'b01) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      if (state0 != 2'b01) break;
      step();
      if (state0 == 2'b01) fill_cycles++;
    end
    checks++; if (fill_cycles !== 8 || state0 !== 2'b00) begin failures++; $display("FAIL lfsr0_fill_len cycles=%0d state=%b exp 8/00", fill_cycles, state0); end
    checks++; if (grid0 !== LFSR_G) begin failures++; $display("FAIL lfsr0_grid got=%h exp=%h", grid0, LFSR_G); end
    @(negedge clk);
    load = 1'b0;
    start = 1'b0;
    seed = '0;
    step();
  endtask

  task automatic test_reset_midrun();
    do_load(BLINK_H);
    @(negedge clk);
    start = 1'b1;
    step();
    repeat (5) step();
    checks++; if (gen0 !== 16'd5 || grid0 !== BLINK_V) begin failures++; $display("FAIL midrun_pre gen=%0d grid=%h exp 5/%h", gen0, grid0, BLINK_V); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (grid0 !== 64'h0 || state0 !== 2'b00) begin failures++; $display("FAIL async_reset grid=%h state=%b exp 0/00", grid0, state0); end
    checks++; if ({gen0, stable0, extinct0, done0} !== 19'h0) begin failures++; $display("FAIL async_reset_flags got=%h exp=0", {gen0, stable0, extinct0, done0}); end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    step();
    checks++; if (state0 !== 2'b00 || grid0 !== 64'h0) begin failures++; $display("FAIL post_reset state=%b grid=%h exp 00/0", state0, grid0); end
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_max_gen();
    test_block();
    test_single();
    test_empty();
    test_glider();
    test_lfsr();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
